// File: rtl/vga_pix_out.sv
// Purpose : VGA pixel output stage; pops pixels from an upstream stream and
//           drives registered RGB, polarity-corrected syncs and data enable.
// Latency : 1 en_i tick from sampled pixel/syncs to outputs.
// Backpressure: pix_ready_o only during active RUN ticks; a missing pixel there
//           is an underrun that blanks and flushes to the next frame boundary.
//
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   en_i                    pixel-clock enable tick
//   run_i                   controller enable; dropping it forces IDLE
//   hvis_i/hsync_i/hend_i   horizontal timing flags
//   vvis_i/vsync_i/vend_i   vertical timing flags
//   hspol_i/vspol_i         sync polarity, 1 = active-high
//   blank_i                 colour shown on active ticks without a pixel
//   pix_valid_i/pix_data_i/pix_ready_o   upstream pixel stream
//   clr_urun_i              clears the sticky underrun flag
//   red_o/green_o/blue_o    registered colour
//   hsync_o/vsync_o/de_o    registered syncs and data enable
//   frm_start_o/flush_o/urun_o  frame start pulse, flush level, sticky underrun
module vga_pix_out #(
    parameter int PIX_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 run_i,
    input  logic                 hvis_i,
    input  logic                 hsync_i,
    input  logic                 hend_i,
    input  logic                 vvis_i,
    input  logic                 vsync_i,
    input  logic                 vend_i,
    input  logic                 hspol_i,
    input  logic                 vspol_i,
    input  logic [PIX_WIDTH-1:0] blank_i,
    input  logic                 pix_valid_i,
    input  logic [PIX_WIDTH-1:0] pix_data_i,
    output logic                 pix_ready_o,
    input  logic                 clr_urun_i,
    output logic [7:0]           red_o,
    output logic [7:0]           green_o,
    output logic [7:0]           blue_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o,
    output logic                 frm_start_o,
    output logic                 flush_o,
    output logic                 urun_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FRM = 2'd1,
        RUN      = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     red_q, red_d;
    logic [7:0]     green_q, green_d;
    logic [7:0]     blue_q, blue_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic           frm_start_q, frm_start_d;
    logic           flush_q, flush_d;
    logic           urun_q, urun_d;

    logic           active;
    logic           frame_end;
    logic           underrun;
    logic           pop;
    logic [PIX_WIDTH-1:0] colour;

    assign active    = hvis_i && vvis_i;
    assign frame_end = en_i && hend_i && vend_i;
    // Gated by reset so that a reset landing mid-line never consumes a pixel.
    assign pix_ready_o = (state_q == RUN) && en_i && active && !rst_i;
    assign pop         = pix_valid_i && pix_ready_o;
    assign underrun    = (state_q == RUN) && en_i && active && !pix_valid_i;

    always_comb begin
        state_d     = state_q;
        frm_start_d = 1'b0;
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        de_d        = de_q;
        flush_d     = flush_q;
        urun_d      = urun_q;
        colour      = '0;

        case (state_q)
            IDLE: begin
                state_d = WAIT_FRM;
            end
            WAIT_FRM: begin
                if (frame_end) begin
                    state_d     = RUN;
                    frm_start_d = 1'b1;
                end
            end
            RUN: begin
                // Underrun wins over a coincident frame end: the rest of the
                // frame is already lost, so flush through the next one.
                if (underrun) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (frame_end) begin
                    state_d     = RUN;
                    frm_start_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!run_i) begin
            state_d     = IDLE;
            frm_start_d = 1'b0;
        end

        if (pop) begin
            colour = pix_data_i;
        end else if (((state_q == RUN) || (state_q == FLUSH)) && active) begin
            colour = blank_i;
        end

        if (en_i) begin
            red_d   = colour[PIX_WIDTH-1 -: 8];
            green_d = colour[PIX_WIDTH-9 -: 8];
            blue_d  = colour[PIX_WIDTH-17 -: 8];
            if (state_q == IDLE) begin
                hsync_d = ~hspol_i;
                vsync_d = ~vspol_i;
            end else begin
                hsync_d = hspol_i ? hsync_i : ~hsync_i;
                vsync_d = vspol_i ? vsync_i : ~vsync_i;
            end
            de_d    = pop;
            flush_d = (state_d == FLUSH);
            // Set has priority over clear.
            urun_d  = underrun || (urun_q && !clr_urun_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            frm_start_q <= 1'b0;
            flush_q     <= 1'b0;
            urun_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            frm_start_q <= frm_start_d;
            flush_q     <= flush_d;
            urun_q      <= urun_d;
        end
    end

    assign red_o       = red_q;
    assign green_o     = green_q;
    assign blue_o      = blue_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign de_o        = de_q;
    assign frm_start_o = frm_start_q;
    assign flush_o     = flush_q;
    assign urun_o      = urun_q;

endmodule

// File: tb/tb_vga_pix_out.sv
// Purpose : self-checking bench for vga_pix_out with a scoreboard queue.
// Latency : expected outputs are queued per clock and checked after each edge.
// Backpressure: pix_ready_o is checked against the bench model every clock.
module tb_vga_pix_out;

    logic        clk;
    logic        rst, en, run;
    logic        hvis, hsync, hend, vvis, vsync, vend;
    logic        hspol, vspol;
    logic [23:0] blank, pix_data;
    logic        pix_valid, pix_ready, clr_urun;
    logic [7:0]  red, green, blue;
    logic        hsync_o, vsync_o, de, frm_start, flush, urun;

    vga_pix_out #(.PIX_WIDTH(24)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .run_i(run),
        .hvis_i(hvis), .hsync_i(hsync), .hend_i(hend),
        .vvis_i(vvis), .vsync_i(vsync), .vend_i(vend),
        .hspol_i(hspol), .vspol_i(vspol), .blank_i(blank),
        .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_ready_o(pix_ready),
        .clr_urun_i(clr_urun),
        .red_o(red), .green_o(green), .blue_o(blue),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de),
        .frm_start_o(frm_start), .flush_o(flush), .urun_o(urun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rgb, hsync, vsync, de, frm_start, flush, urun}
    typedef logic [29:0] exp_t;
    typedef enum int {M_IDLE, M_WAIT, M_RUN, M_FLUSH} mst_t;

    exp_t q[$];
    exp_t m_out;
    mst_t m_st;
    int   total = 0;
    int   bad   = 0;
    int   hc = 0, vc = 0;
    int   en_per = 1;
    int   clk_ctr = 0;
    int   pop_cnt = 0;
    int   frm_cnt = 0;

    // Tiny timing: 8 clocks per line (5 visible), 5 lines per frame (3 visible).
    localparam int HVIS = 5;
    localparam int VVIS = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(posedge clk) begin
        if (pix_valid && pix_ready) pop_cnt++;
        if (frm_start) frm_cnt++;
    end

    // Monitor: one expected output word per clock edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {red, green, blue, hsync_o, vsync_o, de, frm_start, flush, urun};
                chk("outs", {2'b00, a}, {2'b00, e});
            end
        end
    end

    // Apply timing flags for the current position, model the coming edge,
    // queue the expected result, then move to the next negedge.
    task automatic step();
        logic act, fe, rdy, pop, urn, frm;
        logic [23:0] col;
        mst_t nst;
        hvis  = (hc < HVIS);
        hsync = (hc == 5) || (hc == 6);
        hend  = (hc == 7);
        vvis  = (vc < VVIS);
        vsync = (vc == 3);
        vend  = (vc == 4);
        #1;
        act = hvis && vvis;
        fe  = en && hend && vend;
        rdy = !rst && (m_st == M_RUN) && en && act;
        chk("ready", {31'd0, pix_ready}, {31'd0, rdy});
        pop = rdy && pix_valid;
        urn = (m_st == M_RUN) && en && act && !pix_valid;
        if (rst) begin
            m_st  = M_IDLE;
            m_out = '0;
        end else begin
            frm = 1'b0;
            nst = m_st;
            if (!run) nst = M_IDLE;
            else if (m_st == M_IDLE) nst = M_WAIT;
            else if ((m_st == M_WAIT || m_st == M_FLUSH) && fe) begin
                nst = M_RUN;
                frm = 1'b1;
            end else if (m_st == M_RUN && urn) nst = M_FLUSH;
            m_out[2] = frm;
            if (en) begin
                if (pop) col = pix_data;
                else if ((m_st == M_RUN || m_st == M_FLUSH) && act) col = blank;
                else col = 24'h0;
                m_out[29:6] = col;
                m_out[5] = (m_st == M_IDLE) ? ~hspol : (hspol ? hsync : ~hsync);
                m_out[4] = (m_st == M_IDLE) ? ~vspol : (vspol ? vsync : ~vsync);
                m_out[3] = pop;
                m_out[1] = (nst == M_FLUSH);
                m_out[0] = urn ? 1'b1 : (clr_urun ? 1'b0 : m_out[0]);
            end
            m_st = nst;
        end
        q.push_back(m_out);
        if (en) begin
            if (hc == 7) begin
                hc = 0;
                vc = (vc == 4) ? 0 : vc + 1;
            end else begin
                hc++;
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        en = ((clk_ctr % en_per) == 0);
        clk_ctr++;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input int h, input int v);
        int n;
        n = 0;
        while (!(hc == h && vc == v) && n < 2000) begin
            tick();
            n++;
        end
        chk("reach_pos", {31'd0, (hc == h && vc == v)}, 32'd1);
    endtask

    initial begin
        int pc, fc;
        rst = 1'b1; en = 1'b0; run = 1'b0; clr_urun = 1'b0;
        hspol = 1'b1; vspol = 1'b0;
        blank = 24'h102030; pix_data = 24'hA5C3E1; pix_valid = 1'b1;
        m_st = M_IDLE; m_out = '0;
        @(negedge clk);

        // Reset state, with run and enable active to show reset priority.
        run = 1'b1; en = 1'b1; clr_urun = 1'b1;
        step(); step();
        en = 1'b0; run = 1'b0; clr_urun = 1'b0;
        step();
        rst = 1'b0;
        ticks(3);
        hc = 0; vc = 0;

        // Normal frame: wait one frame for the boundary, then one full frame.
        run = 1'b1;
        fc = frm_cnt;
        pc = pop_cnt;
        ticks(40);
        chk("wait_nopop", pop_cnt - pc, 32'd0);
        pc = pop_cnt;
        ticks(40);
        chk("frame_pops", pop_cnt - pc, HVIS * VVIS);
        chk("frm_pulses", frm_cnt - fc, 32'd1);

        // Underrun mid-line, then new polarity.
        hspol = 1'b0; vspol = 1'b1;
        pix_data = 24'h5A3C1E;
        run_until(2, 1);
        pix_valid = 1'b0;
        tick();
        pix_valid = 1'b1;
        pc = pop_cnt;
        fc = frm_cnt;
        run_until(0, 0);
        chk("flush_nopop", pop_cnt - pc, 32'd0);
        tick();
        chk("flush_frm", frm_cnt - fc, 32'd1);

        // Clear underrun, then clear colliding with a new underrun.
        clr_urun = 1'b1;
        tick();
        clr_urun = 1'b0;
        run_until(3, 1);
        pix_valid = 1'b0; clr_urun = 1'b1;
        tick();
        pix_valid = 1'b1; clr_urun = 1'b0;
        run_until(0, 0);
        blank = 24'hFFEEDD;

        // Enable gaps: one tick every 4 clocks over a full frame.
        en_per = 4; clk_ctr = 0;
        ticks(4);
        pc = pop_cnt;
        ticks(160);
        chk("gap_pops", pop_cnt - pc, HVIS * VVIS);

        // run_i drop mid-line on a clock without enable.
        run_until(2, 1);
        run = 1'b0; en = 1'b0;
        step(); step();
        en = 1'b1;
        step();
        en_per = 1; clk_ctr = 0;
        ticks(4);

        // Reset mid-RUN.
        run = 1'b1;
        run_until(0, 0);
        ticks(41);
        run_until(2, 1);
        pc = pop_cnt;
        rst = 1'b1; en = 1'b1;
        step();
        chk("rst_nopop", pop_cnt - pc, 32'd0);
        rst = 1'b0;
        pc = pop_cnt;
        run_until(0, 0);
        chk("rst_wait_nopop", pop_cnt - pc, 32'd0);
        ticks(40);
        chk("rst_frame_pops", pop_cnt - pc, HVIS * VVIS);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/vga_pix_out.md
VGA_PIX_OUT -- requirements
Module: vga_pix_out

Interface
REQ-001 The module SHALL have parameter PIX_WIDTH, default 24, the pixel word width, with {red,green,blue} at 8 bits each.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port en_i, input, 1 bit: the pixel-clock enable tick shared with the timing counters.
REQ-005 The module SHALL have port run_i, input, 1 bit: the controller enable.
REQ-006 The module SHALL have ports hvis_i / hsync_i / hend_i, inputs, 1 bit each: visible, sync and end flags from the horizontal timing counter.
REQ-007 The module SHALL have ports vvis_i / vsync_i / vend_i, inputs, 1 bit each: the same flags from the vertical timing counter.
REQ-008 The module SHALL have ports hspol_i / vspol_i, inputs, 1 bit each: sync polarity, where 1 = active-high.
REQ-009 The module SHALL have port blank_i, input, PIX_WIDTH bits: the colour driven when no valid pixel is shown.
REQ-010 The module SHALL have ports pix_valid_i (input, 1 bit), pix_data_i (input, PIX_WIDTH bits) and pix_ready_o (output, 1 bit): the upstream pixel stream.
REQ-011 The module SHALL have port clr_urun_i, input, 1 bit: clears the sticky underrun flag.
REQ-012 The module SHALL have ports red_o / green_o / blue_o, outputs, 8 bits each: the registered colour.
REQ-013 The module SHALL have ports hsync_o / vsync_o / de_o, outputs, 1 bit each: registered syncs with polarity applied, and data enable.
REQ-014 The module SHALL have ports frm_start_o (output, 1 bit: one-clock pulse), flush_o (output, 1 bit: level) and urun_o (output, 1 bit: sticky underrun).

Function
REQ-015 Terms used below: active = hvis_i && vvis_i; frame_end = en_i && hend_i && vend_i.
REQ-016 The FSM SHALL have exactly the states IDLE, WAIT_FRM, RUN and FLUSH; the encoding is free.
REQ-017 In any state, run_i=0 SHALL move the FSM to IDLE on the next clock; this rule has priority over every other transition.
REQ-018 From IDLE, run_i=1 SHALL move the FSM to WAIT_FRM.
REQ-019 From WAIT_FRM, frame_end SHALL move the FSM to RUN and pulse frm_start_o for that one clock.
REQ-020 In RUN, an underrun (en_i && active && !pix_valid_i) SHALL move the FSM to FLUSH and set urun_o.
REQ-021 In FLUSH, flush_o SHALL be 1; frame_end SHALL move the FSM to RUN with a frm_start_o pulse.
REQ-022 If an underrun and frame_end fall on the same clock in RUN, the FSM SHALL go to FLUSH.
REQ-023 pix_ready_o SHALL be combinational and equal (state==RUN) && en_i && active.
REQ-024 A pixel SHALL be consumed only when pix_valid_i && pix_ready_o; there SHALL be no pops in IDLE, WAIT_FRM or FLUSH.
REQ-025 All outputs except pix_ready_o and frm_start_o SHALL be registered and update only on clocks where en_i=1, holding otherwise.
REQ-026 Latency SHALL be 1 en_i tick: the pixel and syncs sampled at en_i tick N appear on the outputs after the clock edge of tick N.
REQ-027 Colour on an en_i tick SHALL be pix_data_i if consumed; else blank_i if state is RUN or FLUSH and active; else 0.
REQ-028 de_o SHALL be 1 exactly when a pixel is consumed.
REQ-029 hsync_o SHALL equal hsync_i when hspol_i=1 and ~hsync_i when hspol_i=0; vsync_o SHALL follow the same rule with vsync_i/vspol_i.
REQ-030 In IDLE, the syncs SHALL be forced to their inactive level (~pol) and the colour to 0.
REQ-031 Once set, urun_o SHALL hold until clr_urun_i=1; on a simultaneous set and clear, set SHALL win.
REQ-032 blank_i and pol changes SHALL take effect at the next en_i tick; there is no frame-boundary shadowing.

Reset
REQ-033 With rst_i=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-034 Reset SHALL clear red/green/blue_o, hsync_o, vsync_o, de_o, frm_start_o, flush_o and urun_o to 0.
REQ-035 Reset SHALL take priority over run_i, en_i and clr_urun_i.
REQ-036 Reset asserted mid-frame SHALL abort without any pop on that clock; after release the FSM SHALL need run_i and a new frame_end before RUN.

Verification
REQ-037 Scenario, normal frame: with pix_valid_i always 1, assert run_i, then a frame_end. Required: exactly one frm_start_o pulse; the next frame pops exactly H_vis*V_vis pixels, where H_vis and V_vis are the visible pixel and line counts; de_o count matches; each pixel 0xA5C3E1 appears on red/green/blue = A5/C3/E1 one tick later.
REQ-038 Scenario, underrun: drop pix_valid_i for one tick mid-line. Required: blank_i is output at that position; urun_o=1; flush_o=1; no pops until frame_end; then frm_start_o pulses and flush_o=0.
REQ-039 Scenario, polarity: with hspol_i=0 and vspol_i=1, hsync_o is low only during hsync_i and vsync_o is high only during vsync_i.
REQ-040 Scenario, run_i drop: deassert run_i mid-line. Required: next clock the FSM is in IDLE and pix_ready_o=0; on the next en_i tick the colour is 0 and the syncs are at the inactive level.
REQ-041 Scenario, enable gaps: with en_i=1 every 4th clock, the outputs change only on the clock edges of en_i ticks and pix_ready_o is never 1 when en_i=0.
REQ-042 Scenario, reset mid-RUN: assert rst_i mid-RUN, and separately assert clr_urun_i on the same clock as an underrun. Required: rst_i gives all outputs 0 and the FSM in IDLE; the simultaneous set/clear leaves urun_o=1.
